sb_frame_serializer: RTL

//  Parametrised sideband transmit serializer: accepts data words over a valid/ready handshake,

---
 rtl/sb_frame_serializer.sv | 81 ++++++++
 1 files changed

// File: rtl/sb_frame_serializer.sv
// sb_frame_serializer: framed sideband transmit serializer with a one-word hold register
module sb_frame_serializer #(
   parameter int DATA_W     = 8,
   parameter int START_BITS = 1,
   parameter int STOP_BITS  = 1,
   parameter bit LSB_FIRST  = 1'b1,
   parameter int CLK_DIV    = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [1:0]        link_state,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              ser_out,
   output logic              busy,
   output logic              frame_done
);
   localparam int FRAME_W = START_BITS + DATA_W + STOP_BITS;
   localparam int CNT_W   = $clog2(FRAME_W);
   localparam int DIV_W   = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
   typedef enum logic [1:0] {OFF, IDLE, SHIFT} state_t;
   state_t             state;
   logic [DATA_W-1:0]  hold, data_ord;
   logic               hold_valid;
   logic [FRAME_W-1:0] shreg, frame;
   logic [CNT_W-1:0]   bit_cnt;
   logic [DIV_W-1:0]   div_cnt;
   logic               link_up, div_end, last_bit, frame_end, load;
   always_comb begin
      data_ord = '0;
      for (int i = 0; i < DATA_W; i++) data_ord[i] = LSB_FIRST ? hold[i] : hold[DATA_W-1-i];
   end
   // frame[0] is the first bit on the line
   assign frame     = {{STOP_BITS{1'b1}}, data_ord, {START_BITS{1'b0}}};
   assign link_up   = link_state == 2'd1 || link_state == 2'd2;
   assign div_end   = div_cnt == DIV_W'(CLK_DIV - 1);
   assign last_bit  = bit_cnt == CNT_W'(FRAME_W - 1);
   assign frame_end = state == SHIFT && div_end && last_bit;
   assign load      = link_state == 2'd2 && hold_valid && (state == IDLE || frame_end);
   assign in_ready  = state != OFF && !hold_valid;
   always_ff @(posedge clk) begin
      if (rst || !link_up) begin
         state      <= OFF;
         ser_out    <= 1'b0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
         hold_valid <= 1'b0;
         shreg      <= '0;
         bit_cnt    <= '0;
         div_cnt    <= '0;
      end else begin
         frame_done <= frame_end;
         if (in_valid && in_ready) begin
            hold       <= in_data;
            hold_valid <= 1'b1;
         end
         if (load) begin
            state      <= SHIFT;
            busy       <= 1'b1;
            ser_out    <= frame[0];
            shreg      <= frame >> 1;
            bit_cnt    <= '0;
            div_cnt    <= '0;
            hold_valid <= 1'b0;
         end else if (state == SHIFT && !div_end) begin
            div_cnt <= div_cnt + DIV_W'(1);
         end else if (state == SHIFT && !last_bit) begin
            div_cnt <= '0;
            bit_cnt <= bit_cnt + CNT_W'(1);
            ser_out <= shreg[0];
            shreg   <= shreg >> 1;
         end else begin
            // OFF wake-up, idle line, or frame finished with nothing to reload
            state   <= IDLE;
            busy    <= 1'b0;
            ser_out <= 1'b1;
         end
      end
   end
endmodule
